// File: rtl/mul_pkg.sv
// ---------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the sequential LEGv8 multiplier (seq_mul64):
//   mul_state_t      - FSM state encoding (IDLE, RUN, DONE)
//   XZR              - register index 31, the zero register; never written
//   OP_MUL/OP_UMULH  - op encoding: low or high half of the 2*WIDTH product
// ---------------------------------------------------------------------------
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam logic [4:0] XZR      = 5'd31;
  localparam logic       OP_MUL   = 1'b0;
  localparam logic       OP_UMULH = 1'b1;

endpackage : mul_pkg

// File: rtl/shift_add_step.sv
// ---------------------------------------------------------------------------
// shift_add_step
// One iteration of the unsigned shift-add multiply, purely combinational.
//   acc, mcand     : 2*WIDTH-bit partial product and shifted multiplicand
//   mplier         : WIDTH-bit multiplier, consumed LSB first
//   acc_next       : acc + mcand when mplier[0] is set, else acc
//   mcand_next     : mcand shifted left by one
//   mplier_next    : mplier shifted right by one
// ---------------------------------------------------------------------------
module shift_add_step #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] acc_next,
  output logic [2*WIDTH-1:0] mcand_next,
  output logic [WIDTH-1:0]   mplier_next
);

  always_comb begin
    // NOTE: every output gets a default before any conditional update, so no
    // path leaves it unassigned and no latch is inferred.
    acc_next    = acc;
    mcand_next  = mcand << 1;
    mplier_next = mplier >> 1;
    // The sum stays within 2*WIDTH bits for unsigned operands, so the
    // modular add never loses a carry that matters.
    if (mplier[0]) begin
      acc_next = acc + mcand;
    end
  end

endmodule : shift_add_step

// File: rtl/seq_mul64.sv
// ---------------------------------------------------------------------------
// seq_mul64
// Multi-cycle unsigned shift-add multiplier for the LEGv8 execute stage.
// Takes the two register-file read operands and returns a
// WriteData/WriteRegister/RegWrite triple for the register-file write port.
// Latency is fixed: WIDTH RUN cycles followed by one DONE cycle.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous, active-high reset (wins over start)
//   start          request pulse, accepted only in IDLE
//   op             0 = MUL (low half), 1 = UMULH (high half)
//   A, B           multiplicand (ReadData1), multiplier (ReadData2)
//   Rd             destination register index
//   busy           high whenever the FSM is not in IDLE
//   done           one-cycle pulse when WriteData is valid
//   WriteData      selected product half, held until the next result
//   WriteRegister  captured Rd, held until the next result
//   RegWrite       write-enable pulse, suppressed for XZR
// ---------------------------------------------------------------------------
module seq_mul64
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [REG_W-1:0] Rd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] WriteData,
  output logic [REG_W-1:0] WriteRegister,
  output logic             RegWrite
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [REG_W-1:0] ZERO_REG = REG_W'(XZR);

  mul_state_t         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic               op_q;
  logic [REG_W-1:0]   rd_q;

  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] mcand_next;
  logic [WIDTH-1:0]   mplier_next;

  shift_add_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc         (acc),
    .mcand       (mcand),
    .mplier      (mplier),
    .acc_next    (acc_next),
    .mcand_next  (mcand_next),
    .mplier_next (mplier_next)
  );

  // NOTE: state and outputs are updated with non-blocking assignments so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the datapath registers are reset along with the control state
      // so an aborted operation leaves no stale partial product behind.
      state         <= IDLE;
      cnt           <= '0;
      acc           <= '0;
      mcand         <= '0;
      mplier        <= '0;
      op_q          <= OP_MUL;
      rd_q          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      WriteData     <= '0;
      WriteRegister <= '0;
      RegWrite      <= 1'b0;
    end else begin
      // done and RegWrite are single-cycle pulses; only the RUN->DONE
      // transition raises them.
      done     <= 1'b0;
      RegWrite <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, A};
            mplier <= B;
            acc    <= '0;
            cnt    <= '0;
            op_q   <= op;
            rd_q   <= Rd;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end

        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand_next;
          mplier <= mplier_next;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            // Result selection uses acc_next so the final step is included.
            WriteData     <= (op_q == OP_MUL) ? acc_next[WIDTH-1:0]
                                              : acc_next[2*WIDTH-1:WIDTH];
            WriteRegister <= rd_q;
            done          <= 1'b1;
            RegWrite      <= (rd_q != ZERO_REG);
            state         <= DONE;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : seq_mul64

// File: tb/tb_seq_mul64.sv
// ---------------------------------------------------------------------------
// tb_seq_mul64
// Self-checking bench for seq_mul64. Each accepted request pushes its
// expected result (value, destination, write enable, completion cycle) onto
// a scoreboard; a monitor pops and compares whenever done is seen and flags
// any done that arrives early, late, or unexpectedly.
// ---------------------------------------------------------------------------
module tb_seq_mul64;

  localparam int W       = 64;
  localparam int LATENCY = 65;  // edges from accepting edge to done visible

  typedef struct {
    logic [W-1:0] data;
    logic [4:0]   rd;
    logic         rw;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [4:0]   rd;
  logic         busy;
  logic         done;
  logic [W-1:0] write_data;
  logic [4:0]   write_register;
  logic         reg_write;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb[$];

  seq_mul64 #(
    .WIDTH (W),
    .REG_W (5),
    .CNT_W (6)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .op            (op),
    .A             (a),
    .B             (b),
    .Rd            (rd),
    .busy          (busy),
    .done          (done),
    .WriteData     (write_data),
    .WriteRegister (write_register),
    .RegWrite      (reg_write)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor, sampling 1 time unit after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done cyc=%0d got data=%h rd=%0d rw=%b, required no done",
                 cyc, write_data, write_register, reg_write);
      end else begin
        e = sb.pop_front();
        if (cyc !== e.due) begin
          errors++;
          $display("FAIL done_latency got cycle %0d, required %0d", cyc, e.due);
        end
        checks++;
        if (write_data !== e.data) begin
          errors++;
          $display("FAIL write_data got %h, required %h", write_data, e.data);
        end
        checks++;
        if (write_register !== e.rd) begin
          errors++;
          $display("FAIL write_register got %0d, required %0d", write_register, e.rd);
        end
        checks++;
        if (reg_write !== e.rw) begin
          errors++;
          $display("FAIL reg_write got %b, required %b", reg_write, e.rw);
        end
      end
    end else if (done !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL done_known got %b, required 0 or 1", done);
    end
    if (reg_write === 1'b1 && done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL reg_write_pulse got RegWrite=1 with done=%b, required done=1", done);
    end
    if (sb.size() != 0 && cyc > sb[0].due) begin
      checks++;
      errors++;
      $display("FAIL missing_done at cycle %0d got no done, required done at %0d",
               cyc, sb[0].due);
      void'(sb.pop_front());
    end
  end

  // Watchdog: the run must never hang.
  initial begin
    #500000;
    $display("FAIL watchdog got no end of test, required completion within budget");
    $fatal(1, "watchdog expired");
  end

  // Drive one request at a negedge; push an expectation when acceptance is
  // expected. Operands are scrambled after the accepting edge so that a
  // design which fails to capture them produces a wrong product.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic top, input logic [4:0] trd);
    exp_t          e;
    logic [2*W-1:0] p;
    p      = {{W{1'b0}}, ta} * {{W{1'b0}}, tb_v};
    e.data = top ? p[2*W-1:W] : p[W-1:0];
    e.rd   = trd;
    e.rw   = (trd != 5'd31);
    e.due  = cyc + LATENCY;
    sb.push_back(e);
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    op    = top;
    rd    = trd;
    @(negedge clk);
    start = 1'b0;
    a     = {$urandom, $urandom};
    b     = {$urandom, $urandom};
    op    = ~top;
    rd    = trd ^ 5'd5;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start got %b, required 1", busy);
    end
  endtask

  // Wait (bounded) until the scoreboard empties; returns in the DONE cycle.
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got %0d pending results, required 0", sb.size());
      sb.delete();
    end
  endtask

  // Step from the DONE cycle into IDLE and confirm the outputs hold.
  task automatic settle(input logic [W-1:0] hold_data, input logic [4:0] hold_rd);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_idle got %b, required 0", busy);
    end
    checks++;
    if (write_data !== hold_data || write_register !== hold_rd) begin
      errors++;
      $display("FAIL result_hold got data=%h rd=%0d, required data=%h rd=%0d",
               write_data, write_register, hold_data, hold_rd);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;  // must lose to reset
    op    = 1'b0;
    a     = 64'd3;
    b     = 64'd5;
    rd    = 5'd4;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || reg_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got busy=%b done=%b rw=%b, required 0 0 0",
               busy, done, reg_write);
    end
    checks++;
    if (write_data !== '0 || write_register !== '0) begin
      errors++;
      $display("FAIL reset_data got data=%h rd=%0d, required 0 0",
               write_data, write_register);
    end
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_mul_basic();
    issue(64'd3, 64'd5, 1'b0, 5'd4);
    drain();
    settle(64'd15, 5'd4);
  endtask

  task automatic test_umulh();
    issue(64'h8000_0000_0000_0000, 64'd4, 1'b1, 5'd7);
    drain();
    settle(64'd2, 5'd7);
    issue(64'h8000_0000_0000_0000, 64'd4, 1'b0, 5'd7);
    drain();
    settle(64'd0, 5'd7);
  endtask

  task automatic test_max();
    issue('1, '1, 1'b0, 5'd1);
    drain();
    settle(64'd1, 5'd1);
    issue('1, '1, 1'b1, 5'd2);
    drain();
    settle(64'hFFFF_FFFF_FFFF_FFFE, 5'd2);
  endtask

  task automatic test_busy_ignore();
    issue(64'd3, 64'd5, 1'b0, 5'd4);
    repeat (8) @(negedge clk);
    // Request during RUN: no expectation pushed, must be dropped.
    start = 1'b1;
    a     = 64'd9;
    b     = 64'd9;
    op    = 1'b0;
    rd    = 5'd9;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_during_run got %b, required 1", busy);
    end
    drain();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_done got %b, required 1", busy);
    end
    // Request in the DONE cycle: also dropped.
    start = 1'b1;
    a     = 64'd11;
    b     = 64'd11;
    rd    = 5'd11;
    settle(64'd15, 5'd4);
    start = 1'b0;
    // The next IDLE cycle accepts.
    issue(64'd10, 64'd12, 1'b0, 5'd12);
    drain();
    settle(64'd120, 5'd12);
  endtask

  task automatic test_reset_mid_run();
    issue(64'd3, 64'd5, 1'b0, 5'd4);
    repeat (28) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || reg_write !== 1'b0) begin
      errors++;
      $display("FAIL abort_ctrl got busy=%b done=%b rw=%b, required 0 0 0",
               busy, done, reg_write);
    end
    checks++;
    if (write_data !== '0) begin
      errors++;
      $display("FAIL abort_data got %h, required 0", write_data);
    end
    // Stay idle past the aborted operation's completion time.
    repeat (70) @(negedge clk);
    issue(64'd6, 64'd7, 1'b0, 5'd3);
    drain();
    settle(64'd42, 5'd3);
  endtask

  task automatic test_xzr();
    issue(64'd2, 64'd2, 1'b0, 5'd31);
    drain();
    settle(64'd4, 5'd31);
  endtask

  task automatic test_random();
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;
    logic           rop;
    logic [4:0]     rrd;
    logic [2*W-1:0] p;
    for (int i = 0; i < 4; i++) begin
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      rop = 1'($urandom_range(0, 1));
      rrd = 5'($urandom_range(0, 30));
      p   = {{W{1'b0}}, ra} * {{W{1'b0}}, rb};
      issue(ra, rb, rop, rrd);
      drain();
      settle(rop ? p[2*W-1:W] : p[W-1:0], rrd);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    rd    = '0;
    test_reset();
    test_mul_basic();
    test_umulh();
    test_max();
    test_busy_ignore();
    test_reset_mid_run();
    test_xzr();
    test_random();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_seq_mul64
